// File: rtl/bus_responder.sv
// -----------------------------------------------------------------------------
// bus_responder
// Memory/IO responder for a small CPU bus. Every cycle is one transaction
// (mem_wr=1 write, mem_wr=0 read). Addresses with mem_a[17:16]==2'b11 hit the
// IO block; everything else hits a byte RAM indexed by mem_a[RAM_AW-1:0].
// IO map (offset = mem_a[15:0]):
//   0x0000  W: push byte to tx FIFO (0x00 ignored)   R: rx holding byte (clears)
//   0x0004  W: set program_stop, push 0x00           R: counter[7:0], snapshot
//   0x0005..0x0007  R: snapshot bytes 1..3
//
// Ports
//   clk_in, rst_in        clock, async active-high reset
//   mem_a/mem_dout/mem_wr CPU address, write data, write strobe
//   mem_din               registered read data (1-cycle latency)
//   io_buffer_full        tx FIFO near-full (count >= TX_DEPTH-2)
//   tx_data/tx_valid/tx_ready   tx FIFO head and handshake
//   rx_data/rx_valid/rx_ready   rx holding register load and empty flag
//   program_stop, tx_overflow   sticky status flags
// -----------------------------------------------------------------------------
module bus_responder #(
    parameter int RAM_AW   = 17,
    parameter int TX_DEPTH = 8
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic [31:0] mem_a,
    input  logic [7:0]  mem_dout,
    input  logic        mem_wr,
    output logic [7:0]  mem_din,
    output logic        io_buffer_full,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    output logic        program_stop,
    output logic        tx_overflow
);

    localparam int PW = $clog2(TX_DEPTH);
    localparam logic [PW:0]   CNT_DEPTH = TX_DEPTH[PW:0];
    localparam logic [PW:0]   CNT_THR   = CNT_DEPTH - {{(PW-1){1'b0}}, 2'd2};
    localparam logic [PW:0]   CNT_ONE   = {{PW{1'b0}}, 1'b1};
    localparam logic [PW:0]   CNT_ZERO  = {(PW+1){1'b0}};
    localparam logic [PW-1:0] PTR_ONE   = {{(PW-1){1'b0}}, 1'b1};

    localparam logic [15:0] OFF_DATA = 16'h0000;
    localparam logic [15:0] OFF_CNT0 = 16'h0004;
    localparam logic [15:0] OFF_CNT1 = 16'h0005;
    localparam logic [15:0] OFF_CNT2 = 16'h0006;
    localparam logic [15:0] OFF_CNT3 = 16'h0007;

    logic [7:0]        r_ram [0:(1<<RAM_AW)-1];
    logic [7:0]        r_fifo [0:TX_DEPTH-1];
    logic [PW-1:0]     r_wr_ptr;
    logic [PW-1:0]     r_rd_ptr;
    logic [PW:0]       r_count;
    logic              r_rx_full;
    logic [7:0]        r_rx_data;
    logic [31:0]       r_cycle;
    logic [31:0]       r_snap;
    logic [7:0]        r_mem_din;
    logic              r_stop;
    logic              r_ovf;

    logic              w_io;
    logic [15:0]       w_off;
    logic [RAM_AW-1:0] w_ram_idx;
    logic [7:0]        w_io_rdata;
    logic              w_push;
    logic [7:0]        w_push_byte;
    logic              w_pop;
    logic              w_push_ok;
    logic              w_rx_clear;
    logic              w_rd_cnt0;
    logic              w_wr_stop;
    logic              w_unused_addr;

    assign w_io          = (mem_a[17:16] == 2'b11);
    assign w_off         = mem_a[15:0];
    assign w_ram_idx     = mem_a[RAM_AW-1:0];
    assign w_unused_addr = ^mem_a[31:18];

    // IO decode: read data mux, push requests and side-effect strobes
    always_comb begin
        w_io_rdata  = 8'h00;
        w_push      = 1'b0;
        w_push_byte = mem_dout;
        w_rx_clear  = 1'b0;
        w_rd_cnt0   = 1'b0;
        w_wr_stop   = 1'b0;
        case (w_off)
            OFF_DATA: w_io_rdata = r_rx_full ? r_rx_data : 8'h00;
            OFF_CNT0: w_io_rdata = r_cycle[7:0];
            OFF_CNT1: w_io_rdata = r_snap[15:8];
            OFF_CNT2: w_io_rdata = r_snap[23:16];
            OFF_CNT3: w_io_rdata = r_snap[31:24];
            default:  w_io_rdata = 8'h00;
        endcase
        if (w_io && mem_wr) begin
            if (w_off == OFF_DATA) begin
                w_push = (mem_dout != 8'h00);
            end else if (w_off == OFF_CNT0) begin
                w_push      = 1'b1;
                w_push_byte = 8'h00;
                w_wr_stop   = 1'b1;
            end else begin
                w_push = 1'b0;
            end
        end else if (w_io) begin
            w_rx_clear = (w_off == OFF_DATA);
            w_rd_cnt0  = (w_off == OFF_CNT0);
        end else begin
            w_push = 1'b0;
        end
    end

    // A pop frees a slot in the same edge, so a push into a full FIFO is still accepted
    assign w_pop     = (r_count != CNT_ZERO) && tx_ready;
    assign w_push_ok = w_push && ((r_count != CNT_DEPTH) || w_pop);

    // RAM write port; contents are deliberately not reset
    always_ff @(posedge clk_in) begin
        if (mem_wr && !w_io) begin
            r_ram[w_ram_idx] <= mem_dout;
        end
    end

    // tx FIFO storage; only pointers and count are reset
    always_ff @(posedge clk_in) begin
        if (w_push_ok) begin
            r_fifo[r_wr_ptr] <= w_push_byte;
        end
    end

    // Registered read data; holds in write cycles
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_mem_din <= 8'h00;
        end else if (!mem_wr) begin
            r_mem_din <= w_io ? w_io_rdata : r_ram[w_ram_idx];
        end
    end

    // tx FIFO pointers, occupancy and sticky overflow flag
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_wr_ptr <= {PW{1'b0}};
            r_rd_ptr <= {PW{1'b0}};
            r_count  <= CNT_ZERO;
            r_ovf    <= 1'b0;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
            end
            case ({w_push_ok, w_pop})
                2'b10:   r_count <= r_count + CNT_ONE;
                2'b01:   r_count <= r_count - CNT_ONE;
                default: r_count <= r_count;
            endcase
            if (w_push && !w_push_ok) begin
                r_ovf <= 1'b1;
            end
        end
    end

    // rx holding register; a new byte wins over a clearing read in the same cycle
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_rx_full <= 1'b0;
            r_rx_data <= 8'h00;
        end else if (rx_valid && (!r_rx_full || w_rx_clear)) begin
            r_rx_full <= 1'b1;
            r_rx_data <= rx_data;
        end else if (w_rx_clear) begin
            r_rx_full <= 1'b0;
        end
    end

    // Free-running cycle counter, snapshot for consistent multi-byte reads, stop flag
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_cycle <= 32'h0000_0000;
            r_snap  <= 32'h0000_0000;
            r_stop  <= 1'b0;
        end else begin
            r_cycle <= r_cycle + 32'd1;
            if (w_rd_cnt0) begin
                r_snap <= r_cycle;
            end
            if (w_wr_stop) begin
                r_stop <= 1'b1;
            end
        end
    end

    assign mem_din        = r_mem_din;
    assign tx_data        = r_fifo[r_rd_ptr];
    assign tx_valid       = (r_count != CNT_ZERO);
    assign io_buffer_full = (r_count >= CNT_THR);
    assign rx_ready       = !r_rx_full;
    assign program_stop   = r_stop;
    assign tx_overflow    = r_ovf;

endmodule

// File: tb/tb_bus_responder.sv
`timescale 1ns/1ps
module tb_bus_responder;

    localparam int DEPTH = 8;

    logic        clk_in = 1'b0;
    logic        rst_in = 1'b1;
    logic [31:0] mem_a = 32'h0;
    logic [7:0]  mem_dout = 8'h00;
    logic        mem_wr = 1'b0;
    logic [7:0]  mem_din;
    logic        io_buffer_full;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_valid = 1'b0;
    logic        rx_ready;
    logic        program_stop;
    logic        tx_overflow;

    bus_responder #(.RAM_AW(17), .TX_DEPTH(DEPTH)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .mem_a(mem_a), .mem_dout(mem_dout),
        .mem_wr(mem_wr), .mem_din(mem_din), .io_buffer_full(io_buffer_full),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .program_stop(program_stop), .tx_overflow(tx_overflow)
    );

    always #5 clk_in = ~clk_in;

    // Expected visible state after one clock edge
    typedef struct {
        bit         din_known;
        logic [7:0] din;
        logic       txv;
        logic [7:0] txd;
        logic       bfull;
        logic       rxr;
        logic       stop;
        logic       ovf;
    } exp_t;

    exp_t exp_q[$];
    int n_checks = 0;
    int n_errors = 0;

    // Reference model state
    logic [7:0]  m_ram [int];
    logic [7:0]  m_txq [$];
    bit          m_rx_full;
    logic [7:0]  m_rx_byte;
    logic [31:0] m_cnt;
    logic [31:0] m_snap;
    logic [7:0]  m_din;
    bit          m_din_known;
    bit          m_stop;
    bit          m_ovf;

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s: got %02h expected %02h at %0t", nm, act, req, $time);
        end
    endtask

    task automatic m_reset();
        m_txq.delete();
        m_rx_full   = 0;
        m_rx_byte   = 8'h00;
        m_cnt       = 32'h0;
        m_snap      = 32'h0;
        m_din       = 8'h00;
        m_din_known = 1;
        m_stop      = 0;
        m_ovf       = 0;
    endtask

    // Drive one transaction at a negedge, advance the model, queue the expectation
    task automatic cycle(input logic [31:0] a, input logic wr, input logic [7:0] d,
                         input logic txr, input logic rxv, input logic [7:0] rxd);
        exp_t e;
        bit io;
        bit rd_clear;
        logic [15:0] off;
        int idx;
        mem_a = a; mem_wr = wr; mem_dout = d;
        tx_ready = txr; rx_valid = rxv; rx_data = rxd;
        io  = (a[17:16] == 2'b11);
        off = a[15:0];
        idx = int'(a[16:0]);
        rd_clear = !wr && io && (off == 16'h0000);
        if (!wr) begin
            if (io) begin
                m_din_known = 1;
                case (off)
                    16'h0000: m_din = m_rx_full ? m_rx_byte : 8'h00;
                    16'h0004: begin m_din = m_cnt[7:0]; m_snap = m_cnt; end
                    16'h0005: m_din = m_snap[15:8];
                    16'h0006: m_din = m_snap[23:16];
                    16'h0007: m_din = m_snap[31:24];
                    default:  m_din = 8'h00;
                endcase
            end else if (m_ram.exists(idx)) begin
                m_din = m_ram[idx];
                m_din_known = 1;
            end else begin
                m_din_known = 0;
            end
        end else if (!io) begin
            m_ram[idx] = d;
        end
        if (m_txq.size() != 0 && txr) void'(m_txq.pop_front());
        if (wr && io && ((off == 16'h0000 && d != 8'h00) || off == 16'h0004)) begin
            if (m_txq.size() < DEPTH) m_txq.push_back(off == 16'h0004 ? 8'h00 : d);
            else m_ovf = 1;
        end
        if (wr && io && off == 16'h0004) m_stop = 1;
        if (rxv && (!m_rx_full || rd_clear)) begin
            m_rx_full = 1;
            m_rx_byte = rxd;
        end else if (rd_clear) begin
            m_rx_full = 0;
        end
        m_cnt = m_cnt + 32'd1;
        e.din_known = m_din_known;
        e.din   = m_din;
        e.txv   = (m_txq.size() != 0);
        e.txd   = (m_txq.size() != 0) ? m_txq[0] : 8'h00;
        e.bfull = (m_txq.size() >= DEPTH - 2);
        e.rxr   = !m_rx_full;
        e.stop  = m_stop;
        e.ovf   = m_ovf;
        exp_q.push_back(e);
        @(negedge clk_in);
    endtask

    // Assert reset shortly before an edge (a read is in flight) and check it acts at once
    task automatic do_reset();
        #3 rst_in = 1'b1;
        #1;
        chk("rst_tx_valid", {7'b0, tx_valid}, 8'h00);
        chk("rst_mem_din", mem_din, 8'h00);
        chk("rst_buf_full", {7'b0, io_buffer_full}, 8'h00);
        chk("rst_rx_ready", {7'b0, rx_ready}, 8'h01);
        chk("rst_stop", {7'b0, program_stop}, 8'h00);
        chk("rst_ovf", {7'b0, tx_overflow}, 8'h00);
        exp_q.delete();
        @(negedge clk_in);
        @(negedge clk_in);
        rst_in = 1'b0;
        m_reset();
    endtask

    function automatic logic [31:0] rand_addr();
        logic [31:0] a;
        logic [16:0] idx;
        int k;
        a = $urandom;
        k = int'($urandom_range(0, 11));
        if (k < 5) begin
            case (k)
                0:       idx = 17'h00010;
                1:       idx = 17'h00123;
                2:       idx = 17'h0ABCD;
                3:       idx = 17'h1FFFF;
                default: idx = 17'h10000;
            endcase
            a[16:0] = idx;
            if (idx[16]) a[17] = 1'b0;
        end else begin
            a[17:16] = 2'b11;
            case (k)
                5, 6:    a[15:0] = 16'h0000;
                7:       a[15:0] = 16'h0004;
                8:       a[15:0] = 16'h0005;
                9:       a[15:0] = 16'h0006;
                10:      a[15:0] = 16'h0007;
                default: a[15:0] = $urandom_range(0, 1) ? 16'h0008 : 16'hFFFF;
            endcase
        end
        return a;
    endfunction

    // Monitor: compare DUT outputs just after each edge against the queued expectation
    initial begin
        exp_t e;
        forever begin
            @(posedge clk_in);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                if (e.din_known) chk("mem_din", mem_din, e.din);
                chk("tx_valid", {7'b0, tx_valid}, {7'b0, e.txv});
                if (e.txv) chk("tx_data", tx_data, e.txd);
                chk("io_buffer_full", {7'b0, io_buffer_full}, {7'b0, e.bfull});
                chk("rx_ready", {7'b0, rx_ready}, {7'b0, e.rxr});
                chk("program_stop", {7'b0, program_stop}, {7'b0, e.stop});
                chk("tx_overflow", {7'b0, tx_overflow}, {7'b0, e.ovf});
            end
        end
    end

    initial begin
        logic [31:0] a;
        logic wr;
        logic [7:0] d;
        m_reset();
        @(negedge clk_in);
        @(negedge clk_in);
        rst_in = 1'b0;

        // RAM write then read-back, including the bit-17 alias
        cycle(32'h0000_0010, 1'b1, 8'hA5, 1'b0, 1'b0, 8'h00);
        cycle(32'h0000_0010, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
        cycle(32'h0002_0010, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
        cycle(32'h0000_0010, 1'b1, 8'h3C, 1'b0, 1'b0, 8'h00);
        cycle(32'h0002_0010, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00);

        // Zero byte is not pushed; stop register pushes 0x00
        cycle(32'h0003_0000, 1'b1, 8'h00, 1'b0, 1'b0, 8'h00);
        cycle(32'h0003_0004, 1'b1, 8'h77, 1'b0, 1'b0, 8'h00);
        cycle(32'h0003_0004, 1'b1, 8'h00, 1'b1, 1'b0, 8'h00);
        for (int i = 0; i < 3; i++) cycle(32'h0000_0010, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00);

        // Fill the FIFO to overflow, then drain in order
        do_reset();
        for (int i = 0; i < 9; i++) cycle(32'h0003_0000, 1'b1, 8'h41 + 8'(i), 1'b0, 1'b0, 8'h00);
        cycle(32'h0003_0000, 1'b1, 8'h55, 1'b1, 1'b0, 8'h00);
        for (int i = 0; i < 10; i++) cycle(32'h0000_0010, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00);

        // rx holding register: load, read-clear, empty read, load racing a clear
        cycle(32'h0000_0010, 1'b0, 8'h00, 1'b0, 1'b1, 8'h5A);
        cycle(32'h0000_0010, 1'b0, 8'h00, 1'b0, 1'b1, 8'h66);
        cycle(32'h0003_0000, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
        cycle(32'h0003_0000, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
        cycle(32'h0000_0010, 1'b0, 8'h00, 1'b0, 1'b1, 8'h11);
        cycle(32'h0003_0000, 1'b0, 8'h00, 1'b0, 1'b1, 8'h22);
        cycle(32'h0003_0000, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00);

        // Reset mid-stream with three bytes queued
        for (int i = 0; i < 3; i++) cycle(32'h0003_0000, 1'b1, 8'h61 + 8'(i), 1'b0, 1'b0, 8'h00);
        cycle(32'h0000_0123, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
        do_reset();
        cycle(32'h0003_0004, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00);

        // Counter snapshot: read at 0x1FF, then the upper bytes later
        while (m_cnt != 32'h0000_01FF) cycle(32'h0000_0010, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
        cycle(32'h0003_0004, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
        cycle(32'h0000_0010, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
        cycle(32'h0003_0005, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
        cycle(32'h0003_0006, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
        cycle(32'h0003_0007, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00);

        // Randomized traffic with one reset in the middle
        for (int i = 0; i < 3000; i++) begin
            if (i == 1500) do_reset();
            a  = rand_addr();
            wr = ($urandom_range(0, 2) == 0);
            d  = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
            cycle(a, wr, d, ($urandom_range(0, 2) == 0), ($urandom_range(0, 3) == 0), 8'($urandom));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
